i2c_target_rx: RTL and testbench

I2C target (slave) receiver: the responder for the team's i2c_master write transactions. Sits on the shared SCL/SDA bus and oversamples both lines with the system clock. Detects START/STOP, matches a 7-bit address and ACKs it. Receives write data bytes, ACKs each one, and presents them on a one-cycle valid strobe to downstream logic. Read requests are NACKed; no clock stretching.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_line_sync.sv | 32 +++
 rtl/i2c_target_rx.sv | 162 ++++++++++++++++
 tb/tb_i2c_target_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
// State encoding plus address/direction field definitions.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam logic I2C_RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer and edge detector for one open-drain I2C line.
// Flops preset to 1 so reset looks like an idle (released) bus.
module i2c_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C write-only target: address match, byte receive, ACK drive.
// Reads are NACKed; SCL is never stretched.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       addr_hit,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [7:0] byte_cnt,
    output logic       busy,
    output logic       stop_pulse
);

    logic scl_lvl;
    logic scl_rise;
    logic scl_fall;
    logic sda_lvl;
    logic sda_rise;
    logic sda_fall;

    i2c_line_sync #(
        .STAGES (SYNC_STAGES)
    ) u_scl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sda_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_tgt_state_t state;
    logic [7:0]     shreg;
    logic [3:0]     bitcnt;

    logic       start_det;
    logic       stop_det;
    logic [7:0] shnext;
    logic       last_bit;
    logic       addr_ok;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign shnext    = {shreg[6:0], sda_lvl};
    assign last_bit  = (bitcnt == 4'd7);
    assign addr_ok   = (shnext[7:1] == TARGET_ADDR) &&
                       (shnext[0] == I2C_RW_WRITE);

    // bus FSM: START/STOP override everything, else per-state SCL handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= 8'h00;
            bitcnt     <= 4'd0;
            sda_oe     <= 1'b0;
            addr_hit   <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            byte_cnt   <= 8'h00;
            busy       <= 1'b0;
            stop_pulse <= 1'b0;
        end else begin
            addr_hit   <= 1'b0;
            rx_valid   <= 1'b0;
            stop_pulse <= 1'b0;
            if (stop_det) begin
                state      <= ST_IDLE;
                busy       <= 1'b0;
                sda_oe     <= 1'b0;
                stop_pulse <= 1'b1;
                bitcnt     <= 4'd0;
            end else if (start_det) begin
                state    <= ST_ADDR;
                busy     <= 1'b1;
                byte_cnt <= 8'h00;
                bitcnt   <= 4'd0;
                shreg    <= 8'h00;
                sda_oe   <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                    end
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg <= shnext;
                            if (last_bit) begin
                                bitcnt <= 4'd0;
                                state  <= addr_ok ? ST_ADDR_ACK : ST_IGNORE;
                            end else begin
                                bitcnt <= bitcnt + 4'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe   <= 1'b1;
                                addr_hit <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (scl_rise) begin
                            shreg <= shnext;
                            if (last_bit) begin
                                bitcnt   <= 4'd0;
                                rx_data  <= shnext;
                                rx_valid <= 1'b1;
                                if (byte_cnt != 8'hFF) begin
                                    byte_cnt <= byte_cnt + 8'd1;
                                end
                                state <= ST_DATA_ACK;
                            end else begin
                                bitcnt <= bitcnt + 4'd1;
                            end
                        end
                    end
                    ST_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_DATA;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Testbench for i2c_target_rx: bit-banged I2C master on a wired-AND SDA,
// transaction table plus hand-written repeated-START/STOP/reset sequences.
module tb_i2c_target_rx;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       addr_hit;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] byte_cnt;
    logic       busy;
    logic       stop_pulse;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_target_rx #(
        .TARGET_ADDR (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl_drv),
        .sda_i      (sda_bus),
        .sda_oe     (sda_oe),
        .addr_hit   (addr_hit),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .byte_cnt   (byte_cnt),
        .busy       (busy),
        .stop_pulse (stop_pulse)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;
    int         hit_cnt = 0;
    int         stop_cnt = 0;
    int         oe_cyc = 0;
    logic       prev_oe = 1'b0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_drv = 1'b0;
        wclk(4);
        scl_drv = 1'b0;
        wclk(4);
    endtask

    task automatic i2c_rstart;
        sda_drv = 1'b1;
        wclk(4);
        scl_drv = 1'b1;
        wclk(4);
        sda_drv = 1'b0;
        wclk(4);
        scl_drv = 1'b0;
        wclk(4);
    endtask

    task automatic i2c_stop;
        sda_drv = 1'b0;
        wclk(4);
        scl_drv = 1'b1;
        wclk(4);
        sda_drv = 1'b1;
        wclk(8);
    endtask

    task automatic i2c_bit(input logic b, output logic rd);
        sda_drv = b;
        wclk(4);
        scl_drv = 1'b1;
        wclk(4);
        rd = sda_bus;
        wclk(4);
        scl_drv = 1'b0;
        wclk(4);
    endtask

    task automatic i2c_byte(input logic [7:0] v, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(v[i], r);
        i2c_bit(1'b1, r);
        ack = ~r;
    endtask

    // scoreboard and pulse counters; sda_oe must only move while SCL is low
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h want none", rx_data);
                end else begin
                    chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
            if (addr_hit) hit_cnt++;
            if (stop_pulse) stop_cnt++;
            if (sda_oe) oe_cyc++;
            if (sda_oe !== prev_oe) chk("oe_change_scl_low", 32'(scl_drv), 32'd0);
        end
        prev_oe = sda_oe;
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        int         n;
        logic       ack;
        int         hits;
        int         cnt;
    } vec_t;

    vec_t vt[5];

    initial begin
        int   h0;
        int   s0;
        int   r0;
        int   k;
        logic a;
        logic r;
        logic [7:0] d;

        vt[0] = '{8'hA0, 8'hA5, 8'h3C, 2, 1'b1, 1, 2};
        vt[1] = '{8'hA2, 8'h11, 8'h00, 1, 1'b0, 0, 0};
        vt[2] = '{8'hA1, 8'h00, 8'h00, 0, 1'b0, 0, 0};
        vt[3] = '{8'hA0, 8'h00, 8'hFF, 2, 1'b1, 1, 2};
        vt[4] = '{8'h00, 8'h12, 8'h00, 1, 1'b0, 0, 0};

        wclk(3);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_addr_hit", 32'(addr_hit), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stop", 32'(stop_pulse), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
        rst_n = 1'b1;
        wclk(8);

        for (int i = 0; i < 5; i++) begin
            h0 = hit_cnt;
            s0 = stop_cnt;
            r0 = rx_cnt;
            oe_cyc = 0;
            i2c_start();
            chk("busy_after_start", 32'(busy), 32'd1);
            i2c_byte(vt[i].addr, a);
            chk("addr_ack", 32'(a), 32'(vt[i].ack));
            for (int j = 0; j < vt[i].n; j++) begin
                d = (j == 0) ? vt[i].d0 : vt[i].d1;
                if (vt[i].ack) exp_q.push_back(d);
                i2c_byte(d, a);
                chk("data_ack", 32'(a), 32'(vt[i].ack));
            end
            chk("byte_cnt", 32'(byte_cnt), 32'(vt[i].cnt));
            i2c_stop();
            chk("busy_after_stop", 32'(busy), 32'd0);
            chk("stop_count", 32'(stop_cnt - s0), 32'd1);
            chk("addr_hits", 32'(hit_cnt - h0), 32'(vt[i].hits));
            chk("rx_count", 32'(rx_cnt - r0), vt[i].ack ? 32'(vt[i].n) : 32'd0);
            if (!vt[i].ack) chk("oe_never", 32'(oe_cyc), 32'd0);
            wclk(8);
        end

        // repeated START in the middle of a data byte
        h0 = hit_cnt;
        r0 = rx_cnt;
        i2c_start();
        i2c_byte(8'hA0, a);
        chk("rs_addr_ack1", 32'(a), 32'd1);
        exp_q.push_back(8'h77);
        i2c_byte(8'h77, a);
        for (int i = 0; i < 4; i++) i2c_bit(1'b1 ^ i[0], r);
        i2c_rstart();
        chk("rs_cnt_cleared", 32'(byte_cnt), 32'd0);
        i2c_byte(8'hA0, a);
        chk("rs_addr_ack2", 32'(a), 32'd1);
        exp_q.push_back(8'h88);
        i2c_byte(8'h88, a);
        chk("rs_byte_cnt", 32'(byte_cnt), 32'd1);
        i2c_stop();
        chk("rs_hits", 32'(hit_cnt - h0), 32'd2);
        chk("rs_rx_count", 32'(rx_cnt - r0), 32'd2);
        wclk(8);

        // STOP after five data bits
        s0 = stop_cnt;
        r0 = rx_cnt;
        i2c_start();
        i2c_byte(8'hA0, a);
        for (int i = 0; i < 5; i++) i2c_bit(i[0], r);
        i2c_stop();
        chk("mid_rx_count", 32'(rx_cnt - r0), 32'd0);
        chk("mid_state", 32'(dut.state), 32'(ST_IDLE));
        chk("mid_sda_oe", 32'(sda_oe), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_stop", 32'(stop_cnt - s0), 32'd1);
        wclk(8);

        // async reset while the target is driving an ACK
        i2c_start();
        i2c_byte(8'hA0, a);
        exp_q.push_back(8'h42);
        i2c_byte(8'h42, a);
        exp_q.push_back(8'h99);
        for (int i = 7; i >= 0; i--) begin
            d = 8'h99;
            i2c_bit(d[i], r);
        end
        sda_drv = 1'b1;
        k = 0;
        while (!sda_oe && k < 40) begin
            wclk(1);
            k++;
        end
        chk("ack_before_rst", 32'(sda_oe), 32'd1);
        chk("cnt_before_rst", 32'(byte_cnt), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sda_oe", 32'(sda_oe), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_byte_cnt", 32'(byte_cnt), 32'd0);
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        wclk(4);
        rst_n = 1'b1;
        wclk(8);
        h0 = hit_cnt;
        r0 = rx_cnt;
        i2c_start();
        i2c_byte(8'hA0, a);
        chk("post_rst_addr_ack", 32'(a), 32'd1);
        exp_q.push_back(8'h5A);
        i2c_byte(8'h5A, a);
        chk("post_rst_data_ack", 32'(a), 32'd1);
        chk("post_rst_cnt", 32'(byte_cnt), 32'd1);
        i2c_stop();
        chk("post_rst_hits", 32'(hit_cnt - h0), 32'd1);
        chk("post_rst_rx", 32'(rx_cnt - r0), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        wclk(8);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
